jpeg_stream_drain: RTL and testbench
====================================

// Module: jpeg_stream_drain
// PURPOSE
//  Bus initiator that empties the JPEG encoder output FIFO over the XBAR peripheral bus.
//  - Triggered by the encoder's FIFO-level and end-of-stream interrupts.
//  - Reads the FIFO depth, then pops that many 32-bit words and presents them on a valid/ready stream.
//  - After the end-of-stream drain it reads the end-of-stream bit count.
//  Sits between the encoder wrapper's slave port and a downstream DMA/packer.
// PARAMETERS
//  BASE_ADDR    32'h0  encoder slave base; data=BASE+0x000, depth=BASE+0x200, end bits=BASE+0x300
//  ID_W         5      width of bus id
//  ID_VAL       0      constant id driven on every request
//  POLL_CYCLES  1024   poll period (only with JPEG_DRAIN_POLL_EN)
// PORTS
//  clk_i        in   1     clock
//  rst_ni       in   1     reset, asynchronous, active-low
//  enable_i     in   1     0: no new transaction started (in-flight one completes)
//  fifo_irq_i   in   1     encoder FIFO level interrupt (level, depth>8)
//  end_irq_i    in   1     encoder end-of-stream interrupt (1-cycle pulse)
//  error_irq_i  in   1     encoder FIFO full (level)
//  mst_req_o    out  1     bus request
//  mst_add_o    out  32    bus address
//  mst_wen_o    out  1     always 1 (read)
//  mst_wdata_o  out  32    always 0
//  mst_be_o     out  4     always 4'hF
//  mst_id_o     out  ID_W  ID_VAL
//  mst_gnt_i    in   1     bus grant
//  mst_r_valid_i in  1     read response valid
//  mst_r_rdata_i in  32    read response data
//  m_valid_o    out  1     stream word valid
//  m_ready_i    in   1     stream word accepted
//  m_data_o     out  32    compressed stream word
//  m_last_o     out  1     final word of the image
//  done_o       out  1     1-cycle pulse: image fully drained, eof_bits_o updated
//  eof_bits_o   out  5     end-of-stream valid bit count of the final word
//  overflow_o   out  1     sticky: error_irq_i seen high; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, mst_wen_o=1, mst_be_o=4'hF, mst_id_o=ID_VAL, FSM=IDLE, end_pend=0.
//  end_pend: set on end_irq_i in any state; cleared when done_o fires. A pulse during a drain is not lost.
//  Bus: mst_req_o and mst_add_o held stable until mst_gnt_i. Response is on mst_r_valid_i, 1 cycle after the grant.
//  Exactly one read outstanding. The next request is asserted no earlier than the cycle after mst_r_valid_i.
//    (Back-to-back pops return a duplicate word; minimum spacing is 2 cycles per read.)
//  FSM:
//   IDLE   -> DEPTH when enable_i & (fifo_irq_i | end_pend). Request to BASE+0x200.
//   DEPTH  on response: cnt = rdata[4:0]; if rdata[4:0]==0 & error_irq_i, cnt=32 (6-bit counter).
//          cnt==0: -> EOFB if end_pend, else -> IDLE. cnt>0: -> DATA.
//   DATA   request BASE+0x000 only when the output register is empty, or is being accepted this cycle.
//          On response: load m_data_o, assert m_valid_o, cnt--.
//          m_last_o=1 when the loaded word has cnt reaching 0 and end_pend=1.
//          After the last response: -> EOFB if end_pend, else -> IDLE.
//   EOFB   request BASE+0x300. On response: eof_bits_o<=rdata[4:0], done_o pulses, end_pend<=0.
//          -> IDLE, after m_valid_o/m_ready_i of the m_last word has completed.
//  Stream: m_data_o/m_last_o held while m_valid_o & ~m_ready_i. m_valid_o drops the cycle after acceptance unless reloaded.
//  Depth is sampled once per burst. Words pushed during a burst are taken by the next trigger; fifo_irq_i still high retriggers from IDLE.
//  enable_i low mid-burst: the burst completes. enable_i is sampled only in IDLE.
//  Async reset mid-transaction: outstanding read abandoned, mst_req_o dropped immediately, stream word discarded.
// CONFIGURATION
//  JPEG_DRAIN_POLL_EN defined:
//   - Free-running counter of POLL_CYCLES also triggers IDLE->DEPTH when it expires and enable_i=1, draining residues below the irq threshold.
//   - Counter restarts on every IDLE exit.
//  Undefined: triggers are fifo_irq_i and end_pend only; no counter logic.
// TESTING
//  T1 fifo_irq_i=1, depth read returns 9 -> 9 data reads at >=2-cycle spacing, 9 words out in order, m_last_o=0, back to IDLE.
//  T2 end_irq_i pulse, depth=3, end bits=17 -> 3 words, 3rd has m_last_o=1; then read 0x300; done_o 1 cycle; eof_bits_o=17.
//  T3 depth=0 with error_irq_i=1 -> 32 data reads; overflow_o=1 and stays 1.
//  T4 m_ready_i low for 20 cycles after the first word -> no further data read issued; m_data_o stable; resumes on ready.
//  T5 mst_gnt_i held low 5 cycles -> mst_req_o/mst_add_o stable for all 5; end_irq_i pulsed mid-burst -> EOFB reached after burst.
//  T6 (POLL_EN) fifo_irq_i=0, depth=2 residue -> depth read after POLL_CYCLES, 2 words drained; without macro no read occurs.

Source files
------------

// File: rtl/jpeg_stream_drain.sv
// jpeg_stream_drain
//   Bus initiator that empties the JPEG encoder output FIFO over the XBAR
//   peripheral bus. A FIFO-level interrupt, a latched end-of-stream event
//   or (optionally) a poll timer starts a burst: the FIFO depth is read,
//   that many 32-bit words are popped and forwarded on a valid/ready
//   stream, and after the end-of-stream drain the final-word bit count is
//   read back.
//
//   Optional feature macro: JPEG_DRAIN_POLL_EN
//     defined   : a POLL_CYCLES countdown also starts a burst from IDLE, so
//                 residues below the interrupt threshold are drained.
//     undefined : only fifo_irq_i and the latched end event start a burst.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   enable_i                      gates new bursts (sampled in IDLE only)
//   fifo_irq_i / end_irq_i        FIFO level (level) / end of stream (pulse)
//   error_irq_i                   FIFO full; latched into overflow_o
//   mst_req_o .. mst_id_o         read request channel (held until grant)
//   mst_gnt_i                     grant
//   mst_r_valid_i, mst_r_rdata_i  read response, one cycle after grant
//   m_valid_o, m_ready_i          output stream handshake
//   m_data_o, m_last_o            stream word, final word of the image
//   done_o, eof_bits_o            image drained pulse, final-word bit count
//   overflow_o                    sticky FIFO overflow flag

module jpeg_stream_drain #(
  parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000,
  parameter int              ID_W        = 5,
  parameter logic [ID_W-1:0] ID_VAL      = {ID_W{1'b0}},
  parameter int              POLL_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            fifo_irq_i,
  input  logic            end_irq_i,
  input  logic            error_irq_i,
  output logic            mst_req_o,
  output logic [31:0]     mst_add_o,
  output logic            mst_wen_o,
  output logic [31:0]     mst_wdata_o,
  output logic [3:0]      mst_be_o,
  output logic [ID_W-1:0] mst_id_o,
  input  logic            mst_gnt_i,
  input  logic            mst_r_valid_i,
  input  logic [31:0]     mst_r_rdata_i,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [31:0]     m_data_o,
  output logic            m_last_o,
  output logic            done_o,
  output logic [4:0]      eof_bits_o,
  output logic            overflow_o
);

  localparam logic [31:0] ADDR_DATA  = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] ADDR_DEPTH = BASE_ADDR + 32'h0000_0200;
  localparam logic [31:0] ADDR_EOFB  = BASE_ADDR + 32'h0000_0300;

  // FLUSH holds off the return to IDLE until the m_last word has left.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEPTH = 3'd1,
    S_DATA  = 3'd2,
    S_EOFB  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic        req_r;
  logic [31:0] add_r;
  logic        pend_r;
  logic [5:0]  cnt_r;
  logic        end_pend_r;
  logic        m_valid_r;
  logic [31:0] m_data_r;
  logic        m_last_r;
  logic        done_r;
  logic [4:0]  eof_bits_r;
  logic        overflow_r;

  logic        resp_s;
  logic        accept_s;
  logic        slot_free_s;
  logic        bus_idle_s;
  logic        end_pend_now_s;
  logic [5:0]  depth_cnt_s;
  logic        poll_hit_s;
  logic        issue_s;
  logic [31:0] issue_addr_s;

  assign resp_s         = pend_r & mst_r_valid_i;
  assign accept_s       = m_valid_r & m_ready_i;
  // A new pop may be requested if the output register will be empty.
  assign slot_free_s    = ~m_valid_r | accept_s;
  // One read outstanding: nothing requested and no response awaited.
  assign bus_idle_s     = ~req_r & ~pend_r;
  // An end pulse coinciding with the last response still marks that word.
  assign end_pend_now_s = end_pend_r | end_irq_i;
  // A full FIFO reports depth 0 on its 5-bit field; it really holds 32.
  assign depth_cnt_s    = ((mst_r_rdata_i[4:0] == 5'd0) && error_irq_i) ?
                          6'd32 : {1'b0, mst_r_rdata_i[4:0]};

`ifdef JPEG_DRAIN_POLL_EN
  localparam int              POLL_W      = $clog2(POLL_CYCLES + 1);
  localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_CYCLES - 1);

  logic [POLL_W-1:0] poll_cnt_r;

  // Poll countdown: restarts on every IDLE exit, parks at zero when expired.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      poll_cnt_r <= POLL_RELOAD;
    end else if ((state_r == S_IDLE) && (state_nxt_s != S_IDLE)) begin
      poll_cnt_r <= POLL_RELOAD;
    end else if (poll_cnt_r != {POLL_W{1'b0}}) begin
      poll_cnt_r <= poll_cnt_r - POLL_W'(1);
    end else begin
      poll_cnt_r <= poll_cnt_r;
    end
  end

  assign poll_hit_s = (poll_cnt_r == {POLL_W{1'b0}});
`else
  assign poll_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; transitions out of bus states happen on the response.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (enable_i && (fifo_irq_i || end_pend_r || poll_hit_s)) begin
          state_nxt_s = S_DEPTH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DEPTH: begin
        if (resp_s && (depth_cnt_s == 6'd0)) begin
          state_nxt_s = end_pend_now_s ? S_EOFB : S_IDLE;
        end else if (resp_s) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_DEPTH;
        end
      end
      S_DATA: begin
        if (resp_s && (cnt_r == 6'd1)) begin
          state_nxt_s = end_pend_now_s ? S_EOFB : S_IDLE;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_EOFB: begin
        if (resp_s && m_valid_r && !m_ready_i) begin
          state_nxt_s = S_FLUSH;
        end else if (resp_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_EOFB;
        end
      end
      S_FLUSH: begin
        if (slot_free_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output logic: decides when and where the next read is requested.
  always_comb begin
    issue_s      = 1'b0;
    issue_addr_s = ADDR_DATA;
    case (state_r)
      S_DEPTH: begin
        issue_s      = bus_idle_s;
        issue_addr_s = ADDR_DEPTH;
      end
      S_DATA: begin
        issue_s      = bus_idle_s && slot_free_s && (cnt_r != 6'd0);
        issue_addr_s = ADDR_DATA;
      end
      S_EOFB: begin
        issue_s      = bus_idle_s;
        issue_addr_s = ADDR_EOFB;
      end
      default: begin
        issue_s      = 1'b0;
        issue_addr_s = ADDR_DATA;
      end
    endcase
  end

  // Request channel: held until granted, then one response is awaited.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_r  <= 1'b0;
      add_r  <= 32'h0000_0000;
      pend_r <= 1'b0;
    end else if (req_r && mst_gnt_i) begin
      req_r  <= 1'b0;
      pend_r <= 1'b1;
    end else if (issue_s) begin
      req_r  <= 1'b1;
      add_r  <= issue_addr_s;
    end else if (resp_s) begin
      pend_r <= 1'b0;
    end else begin
      req_r  <= req_r;
      pend_r <= pend_r;
    end
  end

  // Burst word counter, sampled once per burst from the depth register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= 6'd0;
    end else if ((state_r == S_DEPTH) && resp_s) begin
      cnt_r <= depth_cnt_s;
    end else if ((state_r == S_DATA) && resp_s) begin
      cnt_r <= cnt_r - 6'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output stream register; holds while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_r <= 1'b0;
      m_data_r  <= 32'h0000_0000;
      m_last_r  <= 1'b0;
    end else if ((state_r == S_DATA) && resp_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= mst_r_rdata_i;
      m_last_r  <= (cnt_r == 6'd1) && end_pend_now_s;
    end else if (accept_s) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
      m_last_r  <= m_last_r;
    end
  end

  // End-of-stream latch; a new pulse wins over the clear so none is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      end_pend_r <= 1'b0;
    end else if (end_irq_i) begin
      end_pend_r <= 1'b1;
    end else if ((state_r == S_EOFB) && resp_s) begin
      end_pend_r <= 1'b0;
    end else begin
      end_pend_r <= end_pend_r;
    end
  end

  // End-of-image reporting and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_r     <= 1'b0;
      eof_bits_r <= 5'd0;
      overflow_r <= 1'b0;
    end else begin
      done_r     <= (state_r == S_EOFB) && resp_s;
      eof_bits_r <= ((state_r == S_EOFB) && resp_s) ? mst_r_rdata_i[4:0] : eof_bits_r;
      overflow_r <= overflow_r | error_irq_i;
    end
  end

  assign mst_req_o   = req_r;
  assign mst_add_o   = add_r;
  assign mst_wen_o   = 1'b1;
  assign mst_wdata_o = 32'h0000_0000;
  assign mst_be_o    = 4'hF;
  assign mst_id_o    = ID_VAL;
  assign m_valid_o   = m_valid_r;
  assign m_data_o    = m_data_r;
  assign m_last_o    = m_last_r;
  assign done_o      = done_r;
  assign eof_bits_o  = eof_bits_r;
  assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_jpeg_stream_drain.sv
// Directed testbench for jpeg_stream_drain with a simple encoder-slave model
// and a stream sink that records every accepted word.

module tb_jpeg_stream_drain;

  localparam logic [31:0] DATA_BASE   = 32'hA500_0000;
  localparam int          POLL_CYCLES = 1024;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        enable    = 1'b0;
  logic        fifo_irq  = 1'b0;
  logic        end_irq   = 1'b0;
  logic        error_irq = 1'b0;
  logic        m_ready   = 1'b0;
  logic        gnt       = 1'b0;
  logic        r_valid   = 1'b0;
  logic [31:0] r_rdata   = 32'h0000_0000;

  logic        mst_req;
  logic [31:0] mst_add;
  logic        mst_wen;
  logic [31:0] mst_wdata;
  logic [3:0]  mst_be;
  logic [4:0]  mst_id;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        done;
  logic [4:0]  eof_bits;
  logic        overflow;

  logic [31:0] depth_val = 32'd0;
  logic [31:0] eof_val   = 32'd0;
  logic        gnt_block = 1'b0;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int unsigned cyc          = 0;
  int unsigned done_cnt     = 0;
  int unsigned spacing_viol = 0;
  int unsigned data_idx     = 0;
  logic        hs_r         = 1'b0;
  logic [31:0] hs_addr_r    = 32'h0000_0000;

  logic [31:0] word_q[$];
  logic        last_q[$];
  logic [31:0] addr_log[$];
  int unsigned cyc_log[$];

  always #5 clk = ~clk;

  jpeg_stream_drain #(
    .BASE_ADDR  (32'h0000_0000),
    .ID_W       (5),
    .ID_VAL     (5'd0),
    .POLL_CYCLES(POLL_CYCLES)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .fifo_irq_i   (fifo_irq),
    .end_irq_i    (end_irq),
    .error_irq_i  (error_irq),
    .mst_req_o    (mst_req),
    .mst_add_o    (mst_add),
    .mst_wen_o    (mst_wen),
    .mst_wdata_o  (mst_wdata),
    .mst_be_o     (mst_be),
    .mst_id_o     (mst_id),
    .mst_gnt_i    (gnt),
    .mst_r_valid_i(r_valid),
    .mst_r_rdata_i(r_rdata),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .m_last_o     (m_last),
    .done_o       (done),
    .eof_bits_o   (eof_bits),
    .overflow_o   (overflow)
  );

  // Bus and stream monitor.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hs_r <= mst_req & gnt;
    if (mst_req & gnt) begin
      hs_addr_r <= mst_add;
      addr_log.push_back(mst_add);
      cyc_log.push_back(cyc);
    end
    if (mst_req & r_valid) spacing_viol <= spacing_viol + 1;
    if (m_valid & m_ready) begin
      word_q.push_back(m_data);
      last_q.push_back(m_last);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Encoder slave: grant unless blocked, respond one cycle after grant.
  always @(negedge clk) begin
    gnt = mst_req & ~gnt_block;
    if (hs_r) begin
      r_valid = 1'b1;
      if (hs_addr_r == 32'h0000_0200) r_rdata = depth_val;
      else if (hs_addr_r == 32'h0000_0300) r_rdata = eof_val;
      else begin
        r_rdata  = DATA_BASE + data_idx;
        data_idx = data_idx + 1;
      end
    end else begin
      r_valid = 1'b0;
      r_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (mst_req !== 1'b0 || mst_add !== 32'h0 || mst_wen !== 1'b1 || mst_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: req=%b add=%h wen=%b wdata=%h, expected 0/0/1/0", mst_req, mst_add, mst_wen, mst_wdata);
    end
    tests_run++;
    if (mst_be !== 4'hF || mst_id !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_be_id: be=%h id=%h, expected f/0", mst_be, mst_id);
    end
    tests_run++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0 || done !== 1'b0 || eof_bits !== 5'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stream: valid=%b last=%b data=%h done=%b eof=%0d ovf=%b, expected all 0", m_valid, m_last, m_data, done, eof_bits, overflow);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fifo_burst();
    int w0, a0, v0, bad, mind;
    int unsigned d0;
    w0 = word_q.size(); a0 = addr_log.size(); d0 = done_cnt; v0 = int'(spacing_viol);
    depth_val = 32'd9; m_ready = 1'b1; fifo_irq = 1'b1; enable = 1'b1;
    for (int n = 0; n < 50 && addr_log.size() == a0; n++) @(negedge clk);
    fifo_irq = 1'b0;
    for (int n = 0; n < 300 && word_q.size() < w0 + 9; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    tests_run++;
    if (word_q.size() !== w0 + 9) begin
      tests_failed++;
      $display("FAIL burst_count: got %0d words, expected 9", word_q.size() - w0);
    end
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (w0 + i >= word_q.size()) bad++;
      else if (word_q[w0+i] !== DATA_BASE + 32'(w0 + i) || last_q[w0+i] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL burst_words: %0d wrong words or last flags, expected 0", bad);
    end
    bad = 0;
    if (addr_log.size() != a0 + 10) bad = 99;
    else begin
      if (addr_log[a0] !== 32'h200) bad++;
      for (int i = 1; i < 10; i++) if (addr_log[a0+i] !== 32'h0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL burst_addrs: %0d address errors over %0d reads, expected 0 over 10", bad, addr_log.size() - a0);
    end
    mind = 1000;
    for (int i = a0 + 2; i < cyc_log.size(); i++)
      if (int'(cyc_log[i] - cyc_log[i-1]) < mind) mind = int'(cyc_log[i] - cyc_log[i-1]);
    tests_run++;
    if (mind < 2 || int'(spacing_viol) !== v0) begin
      tests_failed++;
      $display("FAIL burst_spacing: min gap %0d, req-during-response %0d, expected >=2 and 0", mind, int'(spacing_viol) - v0);
    end
    tests_run++;
    if (mst_req !== 1'b0 || done_cnt !== d0) begin
      tests_failed++;
      $display("FAIL burst_idle: req=%b done pulses=%0d, expected 0/0", mst_req, done_cnt - d0);
    end
    enable = 1'b0;
  endtask

  task automatic test_end_of_stream();
    int w0, a0, bad;
    int unsigned d0;
    w0 = word_q.size(); a0 = addr_log.size(); d0 = done_cnt;
    depth_val = 32'd3; eof_val = 32'd17; m_ready = 1'b1; enable = 1'b1; end_irq = 1'b1;
    @(negedge clk);
    end_irq = 1'b0;
    for (int n = 0; n < 200 && done_cnt == d0; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    bad = 0;
    if (word_q.size() != w0 + 3) bad = 99;
    else for (int i = 0; i < 3; i++) begin
      if (word_q[w0+i] !== DATA_BASE + 32'(w0 + i)) bad++;
      if (last_q[w0+i] !== (i == 2)) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL eos_words: %0d errors over %0d words, expected 0 over 3", bad, word_q.size() - w0);
    end
    bad = 0;
    if (addr_log.size() != a0 + 5) bad = 99;
    else begin
      if (addr_log[a0] !== 32'h200) bad++;
      for (int i = 1; i < 4; i++) if (addr_log[a0+i] !== 32'h0) bad++;
      if (addr_log[a0+4] !== 32'h300) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL eos_addrs: %0d errors over %0d reads, expected 0 over 5", bad, addr_log.size() - a0);
    end
    tests_run++;
    if (eof_bits !== 5'd17 || done_cnt !== d0 + 1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL eos_done: eof_bits=%0d done cycles=%0d, expected 17 and 1", eof_bits, done_cnt - d0);
    end
    enable = 1'b0;
  endtask

  task automatic test_overflow();
    int w0, a0, bad;
    w0 = word_q.size(); a0 = addr_log.size();
    depth_val = 32'd0; error_irq = 1'b1; fifo_irq = 1'b1; m_ready = 1'b1; enable = 1'b1;
    for (int n = 0; n < 50 && addr_log.size() == a0; n++) @(negedge clk);
    fifo_irq = 1'b0;
    for (int n = 0; n < 50 && word_q.size() == w0; n++) @(negedge clk);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: overflow=%b, expected 1", overflow);
    end
    error_irq = 1'b0;
    for (int n = 0; n < 400 && word_q.size() < w0 + 32; n++) @(negedge clk);
    repeat (20) @(negedge clk);
    bad = 0;
    if (word_q.size() != w0 + 32) bad = 99;
    else for (int i = 0; i < 32; i++)
      if (word_q[w0+i] !== DATA_BASE + 32'(w0 + i) || last_q[w0+i] !== 1'b0) bad++;
    tests_run++;
    if (bad !== 0 || addr_log.size() !== a0 + 33) begin
      tests_failed++;
      $display("FAIL ovf_burst: %0d word errors, %0d words, %0d reads, expected 0/32/33", bad, word_q.size() - w0, addr_log.size() - a0);
    end
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: overflow=%b, expected 1", overflow);
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    int w0, a0, bad;
    logic [31:0] hold;
    w0 = word_q.size(); a0 = addr_log.size();
    depth_val = 32'd4; m_ready = 1'b0; fifo_irq = 1'b1; enable = 1'b1;
    for (int n = 0; n < 50 && addr_log.size() == a0; n++) @(negedge clk);
    fifo_irq = 1'b0;
    for (int n = 0; n < 50 && m_valid !== 1'b1; n++) @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== DATA_BASE + 32'(w0)) begin
      tests_failed++;
      $display("FAIL bp_first: valid=%b data=%h, expected 1/%h", m_valid, m_data, DATA_BASE + 32'(w0));
    end
    hold = m_data; bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== hold) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad);
    end
    tests_run++;
    if (addr_log.size() !== a0 + 2) begin
      tests_failed++;
      $display("FAIL bp_noread: %0d reads during stall, expected 2", addr_log.size() - a0);
    end
    m_ready = 1'b1;
    for (int n = 0; n < 100 && word_q.size() < w0 + 4; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    bad = 0;
    if (word_q.size() != w0 + 4) bad = 99;
    else for (int i = 0; i < 4; i++) if (word_q[w0+i] !== DATA_BASE + 32'(w0 + i)) bad++;
    tests_run++;
    if (bad !== 0 || addr_log.size() !== a0 + 5) begin
      tests_failed++;
      $display("FAIL bp_resume: %0d word errors, %0d reads, expected 0 and 5", bad, addr_log.size() - a0);
    end
    enable = 1'b0;
  endtask

  task automatic test_grant_stall();
    int w0, a0, bad;
    int unsigned d0;
    w0 = word_q.size(); a0 = addr_log.size(); d0 = done_cnt;
    depth_val = 32'd5; eof_val = 32'd9; m_ready = 1'b1; gnt_block = 1'b1;
    fifo_irq = 1'b1; enable = 1'b1;
    for (int n = 0; n < 20 && mst_req !== 1'b1; n++) @(negedge clk);
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (mst_req !== 1'b1 || mst_add !== 32'h200) bad++;
    end
    tests_run++;
    if (bad !== 0 || addr_log.size() !== a0) begin
      tests_failed++;
      $display("FAIL gnt_stall: %0d unstable cycles, %0d grants, expected 0 and 0", bad, addr_log.size() - a0);
    end
    gnt_block = 1'b0;
    for (int n = 0; n < 20 && addr_log.size() == a0; n++) @(negedge clk);
    fifo_irq = 1'b0;
    for (int n = 0; n < 100 && word_q.size() < w0 + 2; n++) @(negedge clk);
    end_irq = 1'b1;
    @(negedge clk);
    end_irq = 1'b0;
    for (int n = 0; n < 200 && done_cnt == d0; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    bad = 0;
    if (word_q.size() != w0 + 5) bad = 99;
    else for (int i = 0; i < 5; i++) begin
      if (word_q[w0+i] !== DATA_BASE + 32'(w0 + i)) bad++;
      if (last_q[w0+i] !== (i == 4)) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL mid_end_words: %0d errors over %0d words, expected 0 over 5", bad, word_q.size() - w0);
    end
    tests_run++;
    if (addr_log.size() !== a0 + 7 || eof_bits !== 5'd9 || done_cnt !== d0 + 1) begin
      tests_failed++;
      $display("FAIL mid_end_eofb: reads=%0d eof_bits=%0d done=%0d, expected 7/9/1", addr_log.size() - a0, eof_bits, done_cnt - d0);
    end
    else if (addr_log[a0+6] !== 32'h300) begin
      tests_run++;
      tests_failed++;
      $display("FAIL mid_end_order: last read %h, expected 300", addr_log[a0+6]);
    end
    enable = 1'b0;
  endtask

`ifdef JPEG_DRAIN_POLL_EN
  task automatic test_poll();
    int w0, a0, gap, bad;
    w0 = word_q.size(); a0 = addr_log.size();
    depth_val = 32'd0; m_ready = 1'b1; fifo_irq = 1'b0; enable = 1'b1;
    for (int n = 0; n < 20 && addr_log.size() == a0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    depth_val = 32'd2;
    for (int n = 0; n < 1200 && addr_log.size() < a0 + 2; n++) @(negedge clk);
    gap = (addr_log.size() >= a0 + 2) ? int'(cyc_log[a0+1] - cyc_log[a0]) : 0;
    tests_run++;
    if (gap < 1020 || gap > 1028) begin
      tests_failed++;
      $display("FAIL poll_period: gap %0d cycles, expected about 1024", gap);
    end
    for (int n = 0; n < 50 && word_q.size() < w0 + 2; n++) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    bad = 0;
    if (word_q.size() != w0 + 2) bad = 99;
    else for (int i = 0; i < 2; i++) if (word_q[w0+i] !== DATA_BASE + 32'(w0 + i)) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL poll_drain: %0d errors over %0d words, expected 0 over 2", bad, word_q.size() - w0);
    end
  endtask
`else
  task automatic test_no_poll();
    int a0;
    a0 = addr_log.size();
    depth_val = 32'd2; fifo_irq = 1'b0; enable = 1'b1;
    repeat (1100) @(negedge clk);
    tests_run++;
    if (addr_log.size() !== a0) begin
      tests_failed++;
      $display("FAIL no_poll: %0d reads without trigger, expected 0", addr_log.size() - a0);
    end
    enable = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int a0;
    depth_val = 32'd4; gnt_block = 1'b1; fifo_irq = 1'b1; enable = 1'b1;
    for (int n = 0; n < 20 && mst_req !== 1'b1; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (mst_req !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_req: req=%b overflow=%b, expected 0/0", mst_req, overflow);
    end
    gnt_block = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b0;
    for (int n = 0; n < 50 && m_valid !== 1'b1; n++) @(negedge clk);
    fifo_irq = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || m_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_stream: valid=%b data=%h, expected 0/0", m_valid, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a0 = addr_log.size();
    repeat (20) @(negedge clk);
    tests_run++;
    if (addr_log.size() !== a0 || mst_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_idle: %0d reads, req=%b, expected 0/0", addr_log.size() - a0, mst_req);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fifo_burst();
    test_end_of_stream();
    test_overflow();
    test_backpressure();
    test_grant_stall();
`ifdef JPEG_DRAIN_POLL_EN
    test_poll();
`else
    test_no_poll();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
